neuron_accumulator: RTL and testbench

- Downstream consumer of the 16-lane binary-weight multiplier array.
- Takes one beat per cycle of 16 signed 16-bit lane products, sums them through a registered adder tree, and accumulates across beats until a beat marked last.
- Then saturates the total, optionally applies ReLU, and presents one output neuron value on a valid/ready handshake to the neuron write-back stage.

---
 rtl/nn_pkg.sv | 29 ++
 rtl/neuron_accumulator_if.sv | 30 +++
 rtl/acc_adder_tree.sv | 88 ++++++++
 rtl/neuron_accumulator.sv | 96 +++++++++
 tb/tb_neuron_accumulator.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared neural-datapath package.
// Holds the lane/data/accumulator widths used by the multiplier array and the
// neuron accumulator, the lane-product array type (lane 0 in the low slice),
// and the accumulator-to-output saturation helper.
package nn_pkg;

    localparam int LANES   = 16;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 32;
    localparam int BEATS_W = 8;

    typedef logic signed [DATA_W-1:0] lane_prod_t;
    typedef lane_prod_t [LANES-1:0]   lane_prod_arr_t;

    // Clamp a wide accumulator value into the signed DATA_W output range.
    function automatic logic signed [DATA_W-1:0] sat_to_data(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
        min_v = $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
        if (v > max_v)
            return $signed({1'b0, {(DATA_W-1){1'b1}}});
        else if (v < min_v)
            return $signed({1'b1, {(DATA_W-1){1'b0}}});
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// Stream interface of the neuron accumulator.
// Input side: one beat of LANES signed products per in_valid/in_ready handshake,
// in_last marking the final beat of a neuron.
// Output side: one saturated neuron value plus its beat count per
// out_valid/out_ready handshake.
// master: the environment (upstream producer + downstream consumer).
// slave : the accumulator itself.
interface neuron_accumulator_if;
    import nn_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    lane_prod_arr_t           in_products;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_neuron;
    logic [BEATS_W-1:0]       out_beats;

    modport master (
        output in_valid, in_last, in_products, out_ready,
        input  in_ready, out_valid, out_neuron, out_beats
    );

    modport slave (
        input  in_valid, in_last, in_products, out_ready,
        output in_ready, out_valid, out_neuron, out_beats
    );

endinterface

// File: rtl/acc_adder_tree.sv
// Two-stage registered adder tree for one beat of lane products.
// S1 registers LANES/4 partial sums of four adjacent lanes; S2 registers the
// total of those partials, presented sign-extended to ACC_W. valid and last
// travel alongside the data; last is only ever set together with valid.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (control only)
//   vld_p0/last_p0 accepted beat and its last flag
//   prod_p0        LANES x DATA_W signed products, lane 0 in the low slice
//   s1_last_vld    a last beat currently sits in S1
//   vld_p2/last_p2 S2 holds a beat / that beat is the last one
//   sum_p2         S2 tree sum, sign-extended to ACC_W
module acc_adder_tree #(
    parameter int LANES  = 16,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_p0,
    input  logic                    last_p0,
    input  logic [LANES*DATA_W-1:0] prod_p0,
    output logic                    s1_last_vld,
    output logic                    vld_p2,
    output logic                    last_p2,
    output logic signed [ACC_W-1:0] sum_p2
);

    localparam int GROUPS = LANES / 4;
    localparam int PART_W = DATA_W + 2;
    localparam int SUM_W  = DATA_W + $clog2(LANES);

    logic signed [PART_W-1:0] part_d  [GROUPS];
    logic signed [PART_W-1:0] part_p1 [GROUPS];
    logic                     vld_p1;
    logic                     last_p1;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_r_p2;

    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            part_d[g] = '0;
            for (int k = 0; k < 4; k++)
                part_d[g] = part_d[g] + PART_W'($signed(prod_p0[(4*g+k)*DATA_W +: DATA_W]));
        end
    end

    // ---- S1: partial sums of four lanes ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 && last_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0)
            part_p1 <= part_d;
    end

    always_comb begin
        sum_d = '0;
        for (int g = 0; g < GROUPS; g++)
            sum_d = sum_d + SUM_W'(part_p1[g]);
    end

    // ---- S2: full tree sum ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            last_p2 <= vld_p1 && last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1)
            sum_r_p2 <= sum_d;
    end

    assign sum_p2      = ACC_W'(sum_r_p2);
    assign s1_last_vld = last_p1;

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: sums LANES signed products per beat through a two-stage
// adder tree, accumulates beats until the last one, then saturates to DATA_W,
// optionally clamps negatives to zero, and holds the neuron value and its beat
// count on a valid/ready output.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset; drops any partial neuron
//   bus   slave side of neuron_accumulator_if (input beats, output neuron)
// The pipeline never stalls: new beats are refused while a last beat is in
// the tree or a result is held, so at most one result exists at a time.
module neuron_accumulator #(
    parameter int LANES   = nn_pkg::LANES,
    parameter int DATA_W  = nn_pkg::DATA_W,
    parameter int ACC_W   = nn_pkg::ACC_W,
    parameter int BEATS_W = nn_pkg::BEATS_W,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_accumulator_if.slave  bus
);

    import nn_pkg::*;

    logic                     accept_p0;
    logic                     s1_last_vld;
    logic                     vld_p2;
    logic                     last_p2;
    logic signed [ACC_W-1:0]  sum_p2;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [BEATS_W-1:0]       beat_cnt;
    logic [BEATS_W-1:0]       beat_cnt_inc;
    logic                     out_valid_r;
    logic signed [DATA_W-1:0] out_neuron_r;
    logic [BEATS_W-1:0]       out_beats_r;

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
        if (RELU_EN && v < 0)
            return '0;
        return v;
    endfunction

    assign bus.in_ready = !(out_valid_r || s1_last_vld || (vld_p2 && last_p2));
    assign accept_p0    = bus.in_valid && bus.in_ready;

    acc_adder_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_tree (
        .clk         (clk),
        .rst         (rst),
        .vld_p0      (accept_p0),
        .last_p0     (bus.in_last),
        .prod_p0     (bus.in_products),
        .s1_last_vld (s1_last_vld),
        .vld_p2      (vld_p2),
        .last_p2     (last_p2),
        .sum_p2      (sum_p2)
    );

    assign acc_next     = acc + sum_p2;
    assign beat_cnt_inc = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;

    // ---- S3: accumulate, finalise on last, output handshake ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc          <= '0;
            beat_cnt     <= '0;
            out_valid_r  <= 1'b0;
            out_neuron_r <= '0;
            out_beats_r  <= '0;
        end else begin
            if (out_valid_r && bus.out_ready)
                out_valid_r <= 1'b0;
            if (vld_p2) begin
                if (last_p2) begin
                    out_neuron_r <= relu(sat_to_data(acc_next));
                    out_beats_r  <= beat_cnt_inc;
                    out_valid_r  <= 1'b1;
                    acc          <= '0;
                    beat_cnt     <= '0;
                end else begin
                    acc      <= acc_next;
                    beat_cnt <= beat_cnt_inc;
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_neuron = out_neuron_r;
    assign bus.out_beats  = out_beats_r;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: two instances share one stimulus
// stream, one with ReLU enabled and one without, so both output modes are
// exercised on identical beats.
module tb_neuron_accumulator;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    neuron_accumulator_if bus_r ();
    neuron_accumulator_if bus_n ();

    neuron_accumulator #(.RELU_EN(1'b1)) u_dut_relu (
        .clk (clk),
        .rst (rst),
        .bus (bus_r.slave)
    );

    neuron_accumulator #(.RELU_EN(1'b0)) u_dut_lin (
        .clk (clk),
        .rst (rst),
        .bus (bus_n.slave)
    );

    assign bus_n.in_valid    = bus_r.in_valid;
    assign bus_n.in_last     = bus_r.in_last;
    assign bus_n.in_products = bus_r.in_products;
    assign bus_n.out_ready   = bus_r.out_ready;

    int vec_cnt = 0;
    int err_cnt = 0;
    int qa[$];
    int qb[$];
    int qbeats[$];

    // Record every completed output handshake of both instances.
    always @(negedge clk) begin
        if (rst) begin
            if (bus_r.out_valid && bus_r.out_ready) begin
                qa.push_back(int'(bus_r.out_neuron));
                qbeats.push_back(int'(bus_r.out_beats));
            end
            if (bus_n.out_valid && bus_n.out_ready)
                qb.push_back(int'(bus_n.out_neuron));
        end
    end

    task automatic check_vec(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic lane_prod_arr_t fill(input int v);
        lane_prod_arr_t f;
        for (int i = 0; i < LANES; i++)
            f[i] = DATA_W'(v);
        return f;
    endfunction

    function automatic lane_prod_arr_t alt_pat();
        lane_prod_arr_t f;
        for (int i = 0; i < LANES; i++)
            f[i] = (i % 2 == 0) ? 16'sd5 : -16'sd3;
        return f;
    endfunction

    function automatic lane_prod_arr_t idx_pat();
        lane_prod_arr_t f;
        for (int i = 0; i < LANES; i++)
            f[i] = DATA_W'(i);
        return f;
    endfunction

    // Present a beat and hold it until accepted; leaves in_valid high so
    // consecutive calls stream back-to-back.
    task automatic push_beat(input lane_prod_arr_t p, input logic last);
        int guard = 0;
        bus_r.in_products = p;
        bus_r.in_last     = last;
        bus_r.in_valid    = 1'b1;
        while (!bus_r.in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 40)
            check_vec("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // Drop in_valid and put junk on the data lines, which must be ignored.
    task automatic idle();
        bus_r.in_valid    = 1'b0;
        bus_r.in_last     = 1'b1;
        bus_r.in_products = fill(16'h7abc);
    endtask

    task automatic expect_result(input string tag, input int exp_a, input int exp_b, input int exp_beats);
        int guard = 0;
        while ((qa.size() == 0 || qb.size() == 0) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (qa.size() == 0 || qb.size() == 0) begin
            check_vec({tag, "_timeout"}, 0, 1);
        end else begin
            check_vec({tag, "_relu"},  qa.pop_front(),     exp_a);
            check_vec({tag, "_lin"},   qb.pop_front(),     exp_b);
            check_vec({tag, "_beats"}, qbeats.pop_front(), exp_beats);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus_r.out_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // reset state
        check_vec("rst_out_valid",  int'(bus_r.out_valid), 0);
        check_vec("rst_out_neuron", int'(bus_r.out_neuron), 0);
        check_vec("rst_out_beats",  int'(bus_r.out_beats), 0);
        check_vec("rst_in_ready",   int'(bus_r.in_ready), 1);

        // single beat with latency checks
        push_beat(fill(1), 1'b1);
        idle();
        check_vec("lat_e0_valid", int'(bus_r.out_valid), 0);
        @(posedge clk); #1;
        check_vec("lat_e1_valid", int'(bus_r.out_valid), 0);
        check_vec("lat_e1_ready", int'(bus_r.in_ready), 0);
        @(posedge clk); #1;
        check_vec("lat_e2_valid", int'(bus_r.out_valid), 1);
        expect_result("single", 16, 16, 1);

        // multi-beat, then accumulator must start from zero
        push_beat(fill(100), 1'b0);
        push_beat(fill(100), 1'b0);
        push_beat(fill(100), 1'b1);
        idle();
        expect_result("multi", 4800, 4800, 3);
        push_beat(fill(-1), 1'b1);
        idle();
        expect_result("neg_one", 0, -16, 1);

        // positive and negative saturation
        for (int i = 0; i < 4; i++)
            push_beat(fill(32767), i == 3);
        idle();
        expect_result("sat_pos", 32767, 32767, 4);
        push_beat(fill(-32768), 1'b0);
        push_beat(fill(-32768), 1'b1);
        idle();
        expect_result("sat_neg", 0, -32768, 2);

        // backpressure
        bus_r.out_ready = 1'b0;
        push_beat(fill(3), 1'b1);
        idle();
        guard = 0;
        while (!bus_r.out_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_vec("bp_valid", int'(bus_r.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_vec("bp_in_ready", int'(bus_r.in_ready), 0);
            check_vec("bp_hold_relu", int'(bus_r.out_neuron), 48);
            check_vec("bp_hold_lin", int'(bus_n.out_neuron), 48);
        end
        bus_r.out_ready = 1'b1;
        @(posedge clk); #1;
        check_vec("bp_released_valid", int'(bus_r.out_valid), 0);
        check_vec("bp_released_ready", int'(bus_r.in_ready), 1);
        expect_result("bp", 48, 48, 1);
        repeat (3) @(posedge clk);
        #1 check_vec("bp_single", qa.size(), 0);

        // reset in the middle of a neuron
        push_beat(fill(50), 1'b0);
        push_beat(fill(50), 1'b0);
        idle();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_vec("abort_no_out", qa.size(), 0);
        check_vec("abort_valid", int'(bus_r.out_valid), 0);
        push_beat(fill(2), 1'b1);
        idle();
        expect_result("after_rst", 32, 32, 1);

        // mixed-sign lanes, back-to-back neurons of two beats each
        push_beat(alt_pat(), 1'b0);
        push_beat(alt_pat(), 1'b1);
        push_beat(idx_pat(), 1'b0);
        push_beat(idx_pat(), 1'b1);
        push_beat(fill(7), 1'b0);
        push_beat(fill(-9), 1'b1);
        idle();
        expect_result("mixed", 32, 32, 2);
        expect_result("ramp", 240, 240, 2);
        expect_result("mix_neg", 0, -32, 2);
        repeat (5) @(posedge clk);
        #1 check_vec("no_extra", qa.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
